// File: rtl/peak_pkg.sv
// Shared types and width constants for the peak_capture pulse-height stage.
package peak_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int unsigned PEAK_W = 14;
    localparam int unsigned TS_W   = 32;

endpackage

// File: rtl/holdoff_timer.sv
// Dead-time down-counter; done is a registered flag meaning "the next decrement reaches zero".
module holdoff_timer #(
    parameter int unsigned LOAD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    output logic [7:0] count,
    output logic       done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
            done  <= 1'b0;
        end else if (load) begin
            count <= 8'(LOAD);
            done  <= (LOAD == 32'd1);
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
            done  <= (count == 8'd2);
        end
    end

endmodule

// File: rtl/peak_capture.sv
// Threshold-triggered peak detector with hold-off and a valid/ready peak register.
// Optional PEAK_TIMESTAMP_EN adds a cycle counter and a TS port latched at the trigger edge.
module peak_capture
    import peak_pkg::*;
#(
    parameter int unsigned W       = PEAK_W,
    parameter int          THRESH  = 100,
    parameter int unsigned HYST    = 8,
    parameter int unsigned HOLDOFF = 16
) (
    input  logic            CLK,
    input  logic            CLRN,
    input  logic            EN,
    input  logic [W-1:0]    X,
    output logic [W-1:0]    PEAK,
    output logic            PV,
    input  logic            PR,
    output logic            BUSY,
`ifdef PEAK_TIMESTAMP_EN
    output logic [TS_W-1:0] TS,
`endif
    output logic [7:0]      DROP
);

    localparam int unsigned XW = W + 1;

    state_t            state_q, state_d;
    logic [W-1:0]      max_q, max_d, peak_q;
    logic              pv_q, pv_d, busy_q;
    logic [7:0]        drop_q;
    logic signed [W:0] x_e, max_e, thr_e, floor_e;
    logic              above_c, confirm_c, take_c, load_c, dec_c, done;
    logic [7:0]        hold_cnt;

    // Sign-extend to W+1 bits so max - HYST cannot wrap at the most negative sample
    assign x_e     = {X[W-1], X};
    assign max_e   = {max_q[W-1], max_q};
    assign thr_e   = XW'(THRESH);
    assign floor_e = max_e - XW'(HYST);
    assign above_c = (x_e > thr_e);

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        confirm_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (EN && above_c) begin
                    state_d = RISE;
                    max_d   = X;
                end
            end
            RISE: begin
                if (!EN) begin
                    state_d = IDLE;
                end else if (x_e > max_e) begin
                    max_d = X;
                end else if ((x_e < floor_e) || !above_c) begin
                    confirm_c = 1'b1;
                    state_d   = above_c ? FALL : HOLD;
                end
            end
            FALL: begin
                if (!EN) begin
                    state_d = IDLE;
                end else if (!above_c) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_c = (state_d == HOLD) && (state_q != HOLD);
    assign dec_c  = (state_q == HOLD) && (hold_cnt != 8'd0);
    assign take_c = confirm_c && (!pv_q || PR);

    // A new emit wins over the handshake clearing PV
    always_comb begin
        pv_d = pv_q;
        if (take_c) begin
            pv_d = 1'b1;
        end else if (pv_q && PR) begin
            pv_d = 1'b0;
        end
    end

    holdoff_timer #(
        .LOAD (HOLDOFF)
    ) u_holdoff (
        .clk   (CLK),
        .rst_n (CLRN),
        .load  (load_c),
        .dec   (dec_c),
        .count (hold_cnt),
        .done  (done)
    );

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= IDLE;
            max_q   <= '0;
            peak_q  <= '0;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            pv_q    <= pv_d;
            busy_q  <= (state_d != IDLE);
            if (take_c) begin
                peak_q <= max_q;
            end
            if (confirm_c && !take_c && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign PEAK = peak_q;
    assign PV   = pv_q;
    assign BUSY = busy_q;
    assign DROP = drop_q;

`ifdef PEAK_TIMESTAMP_EN
    logic [TS_W-1:0] cyc_q, trig_q, ts_q;
    logic            trig_c;

    assign trig_c = (state_q == IDLE) && (state_d == RISE);

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            cyc_q  <= '0;
            trig_q <= '0;
            ts_q   <= '0;
        end else begin
            cyc_q <= cyc_q + TS_W'(1);
            if (trig_c) begin
                trig_q <= cyc_q;
            end
            if (take_c) begin
                ts_q <= trig_q;
            end
        end
    end

    assign TS = ts_q;
`endif

endmodule

// File: doc/peak_capture.md
# peak_capture

Pulse-height capture stage that sits downstream of the `conforming` shaping filter and consumes its 14-bit signed shaped output. It detects each shaped pulse crossing a threshold, tracks its maximum, and emits the peak amplitude through a valid/ready output register. A hold-off dead time follows each pulse. Pulses that complete while the output register is still occupied are counted as drops.

## Interface
- `W`, 14: sample and peak width in bits (signed).
- `THRESH`, 100: signed trigger level. A pulse starts when `X > THRESH`.
- `HYST`, 8: unsigned fall-back from the running maximum that confirms a peak.
- `HOLDOFF`, 16: dead-time cycles after the pulse returns to or below `THRESH`. Range 1..255.
- `CLK` in 1: sole clock, rising edge.
- `CLRN` in 1: asynchronous, active-low reset.
- `EN` in 1: sample qualifier, tied to the filter's `OE`. `X` is ignored while `EN` is low.
- `X` in W: signed shaped sample from the `conforming` output `Y`.
- `PEAK` out W: signed captured peak amplitude. Valid while `PV` is high.
- `PV` out 1: peak valid.
- `PR` in 1: downstream ready.
- `BUSY` out 1: high in every state except IDLE.
- `DROP` out 8: saturating count of peaks lost to a full output register.

## Operation
- States are IDLE, RISE, FALL and HOLD.
- **IDLE**
  - On a sample with `EN=1` and `X > THRESH`: set max to `X`, go to RISE.
- **RISE** (only on samples with `EN=1`)
  - If `X > max`: max ← `X`.
  - Else if `X < max − HYST` or `X <= THRESH`: peak confirmed, attempt emit, go to FALL.
- **Emit**
  - If `PV=0`, or `PV=1` with `PR=1` in the same cycle: `PEAK` ← max and `PV` ← 1.
  - Otherwise `DROP` increments (saturating at 255) and `PEAK` is left unchanged.
- **FALL**
  - When `EN=1` and `X <= THRESH`: load the hold-off counter with `HOLDOFF`, go to HOLD.
  - If the confirming sample itself is `<= THRESH`, RISE goes straight to HOLD; the emit rule still applies.
- **HOLD**
  - Counter decrements every cycle regardless of `EN`. At 0, go to IDLE.
  - Threshold crossings during HOLD are ignored.
- **EN low in RISE or FALL**: abort to IDLE with no emit and no drop. The output register is unaffected.
- **Output handshake**: `PV` clears on the cycle after `PV && PR` unless a new emit occurs in that same cycle.
- **Arithmetic**
  - All comparisons are signed.
  - `max − HYST` is computed at W+1 bits so it cannot wrap at −8192.
  - A max equal to −8192 is legal.
  - Equal samples in RISE neither update max nor confirm a peak.

## Timing
- Reset values:
  - State IDLE, max 0, counter 0.
  - `PEAK` 0, `PV` 0, `BUSY` 0, `DROP` 0.
- Trigger: the rising edge that samples `X > THRESH` moves the state to RISE. `BUSY` goes high after that edge.
- Peak latency: `PV` rises on the edge that samples the confirming sample, i.e. 1 clock after that sample is presented.
- Dead time: HOLD lasts exactly `HOLDOFF` cycles. IDLE can re-trigger on the sample presented on the clock after the counter reaches 0.
- Simultaneous emit with `PV && PR`: new data loads and `PV` stays high. No drop is counted.
- `CLRN` asserted mid-pulse: every output clears immediately and asynchronously. Removal is synchronous to `CLK`.

## Configuration
- Macro `PEAK_TIMESTAMP_EN`.
- **Defined**:
  - A free-running 32-bit cycle counter is added, cleared by `CLRN`.
  - Output port `TS` (32 bits) is added. It holds the counter value at the trigger edge (IDLE→RISE) and updates together with `PEAK`.
- **Undefined**: no counter and no `TS` port. All other behaviour is identical.

## Structure
- Package `peak_pkg` holds:
  - the state enum (IDLE, RISE, FALL, HOLD);
  - the default width constant `PEAK_W = 14`;
  - the timestamp width constant `TS_W = 32`.
- Sub-module `holdoff_timer` provides:
  - load, decrement and `done` signals;
  - an 8-bit count;
  - a parameterised load value.
- FSM, max tracking and the output register stay in the top level.

## Test plan
- **Reset**: hold `CLRN=0` while driving `X=2000, EN=1` → `PV=0`, `PEAK=0`, `DROP=0`, `BUSY=0`. After release, the first sample above 100 triggers.
- **Single pulse**
  - Stimulus: `X` = 0, 500, 1250, 1200, 900, 0 with `EN=1` and `PR=1`.
  - Required: `PEAK=1250` with `PV` high for one cycle, 1 clock after the 1200 sample. IDLE is re-entered 16 cycles after the 0 sample.
- **Drop**
  - Stimulus: two pulses with peaks 1250 and 800, `PR=0` throughout.
  - Required: `PEAK=1250` stays with `PV=1`, and `DROP=1`.
- **Negative and boundary values**
  - `THRESH=-200`, pulse −100, −50, −60 → `PEAK=-50`.
  - `X=-8192` with `THRESH=-8192` → no trigger.
- **Abort and hold-off**
  - `EN` dropped mid-RISE → no `PV`, no drop, IDLE.
  - A crossing during HOLD → no trigger.
- **Timestamp** (with `PEAK_TIMESTAMP_EN`): a trigger at cycle 37 after reset → `TS=37` with the peak.
